timing_control_team1: RTL and testbench

- Control-side front end of the basic computer that produces the T, D, B and I inputs consumed by the AC/E control decoders.
- Contains the sequence counter (SC) with its 4-to-16 timing decoder, the instruction register (IR), the opcode decoder, the indirect flip-flop I, and the start/stop flip-flop S.
- Sits between the common bus and all register-control logic.
- Clears SC at the end of every instruction and stops the machine on HLT.

---
 rtl/timing_control_team1.sv | 79 +++++++
 tb/tb_timing_control_team1.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/timing_control_team1.sv
// Basic-computer control front end: sequence counter with timing decode, IR,
// opcode decode, indirect flip-flop I and the start/stop (run) flip-flop S.
module timing_control_team1 #(
   parameter int size = 16
) (
   input  logic            clk,
   input  logic            CLR_GLOBAL,
   input  logic            START,
   input  logic [size-1:0] BUS_IN,
   output logic [15:0]     T,
   output logic [7:0]      D,
   output logic [11:0]     B,
   output logic            I,
   output logic            S,
   output logic [3:0]      SC
);

   typedef enum logic {ST_HALT = 1'b0, ST_RUN = 1'b1} run_state_t;

   run_state_t      state_q, state_d;
   logic [3:0]      sc_q, sc_d;
   logic [size-1:0] ir_q, ir_d;
   logic            i_q, i_d;

   logic [15:0] t_dec;
   logic [7:0]  d_dec;
   logic        r_cyc, p_cyc, clr_sc, hlt;

   always_ff @(posedge clk or posedge CLR_GLOBAL) begin
      if (CLR_GLOBAL) begin
         state_q <= ST_HALT;
         sc_q    <= 4'd0;
         ir_q    <= '0;
         i_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         ir_q    <= ir_d;
         i_q     <= i_d;
      end
   end

   always_comb begin
      t_dec   = (state_q == ST_RUN) ? (16'h0001 << sc_q) : 16'h0000;
      d_dec   = 8'h01 << ir_q[14:12];
      r_cyc   = d_dec[7] & ~i_q & t_dec[3];
      p_cyc   = d_dec[7] &  i_q & t_dec[3];
      // End-of-instruction: each opcode class finishes at its own timing step.
      clr_sc  = r_cyc | p_cyc
              | ((d_dec[0] | d_dec[1] | d_dec[2]) & t_dec[5])
              | ((d_dec[3] | d_dec[4]) & t_dec[4])
              | (d_dec[5] & t_dec[5])
              | (d_dec[6] & t_dec[6]);
      hlt     = r_cyc & ir_q[0];

      state_d = state_q;
      sc_d    = sc_q;
      ir_d    = ir_q;
      i_d     = i_q;

      if (state_q == ST_HALT) begin
         sc_d = 4'd0;
         if (START) state_d = ST_RUN;
      end else begin
         sc_d = clr_sc ? 4'd0 : sc_q + 4'd1;
         if (hlt)       state_d = ST_HALT;
         if (t_dec[1])  ir_d    = BUS_IN;
         if (t_dec[2])  i_d     = ir_q[15];
      end
   end

   assign T  = t_dec;
   assign D  = d_dec;
   assign B  = ir_q[11:0];
   assign I  = i_q;
   assign S  = (state_q == ST_RUN);
   assign SC = sc_q;

endmodule

// File: tb/tb_timing_control_team1.sv
// Directed bench for timing_control_team1: fetch/decode timing, per-opcode
// clear points, HLT/restart and asynchronous reset.
module tb_timing_control_team1;

   logic        clk = 1'b0;
   logic        CLR_GLOBAL;
   logic        START;
   logic [15:0] BUS_IN;
   logic [15:0] T;
   logic [7:0]  D;
   logic [11:0] B;
   logic        I;
   logic        S;
   logic [3:0]  SC;

   int total = 0;
   int bad   = 0;

   timing_control_team1 #(.size(16)) dut (
      .clk        (clk),
      .CLR_GLOBAL (CLR_GLOBAL),
      .START      (START),
      .BUS_IN     (BUS_IN),
      .T          (T),
      .D          (D),
      .B          (B),
      .I          (I),
      .S          (S),
      .SC         (SC)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      CLR_GLOBAL = 1'b1;
      START      = 1'b0;
      BUS_IN     = 16'h0000;
      tick();
      tick();
      total++;
      if ({S, SC, T, D, B, I} !== {1'b0, 4'd0, 16'h0000, 8'h01, 12'h000, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: S=%b SC=%0d T=%h D=%h B=%h I=%b", S, SC, T, D, B, I);
      end
      CLR_GLOBAL = 1'b0;
      tick();
      total++;
      if ({S, SC, T} !== {1'b0, 4'd0, 16'h0000}) begin
         bad++;
         $display("FAIL halted_idle: S=%b SC=%0d T=%h want S=0 SC=0 T=0", S, SC, T);
      end
   endtask

   task automatic test_start();
      START = 1'b1;
      tick();
      START = 1'b0;
      total++;
      if ({S, SC, T} !== {1'b1, 4'd0, 16'h0001}) begin
         bad++;
         $display("FAIL start: S=%b SC=%0d T=%h want S=1 SC=0 T=0001", S, SC, T);
      end
   endtask

   // Starts at T[0]; fetches one instruction and checks every step up to the
   // step where SC must clear, then checks the return to T[0].
   task automatic run_instr(input string name, input logic [15:0] instr,
                            input logic [7:0] exp_d, input logic exp_i,
                            input int clr_step);
      BUS_IN = instr;
      tick();
      total++;
      if (T !== 16'h0002 || SC !== 4'd1) begin
         bad++;
         $display("FAIL %s_t1: T=%h SC=%0d want T=0002 SC=1", name, T, SC);
      end
      tick();
      BUS_IN = 16'h0000;
      total++;
      if (T !== 16'h0004 || D !== exp_d || B !== instr[11:0]) begin
         bad++;
         $display("FAIL %s_t2: T=%h D=%h B=%h want T=0004 D=%h B=%h",
                  name, T, D, B, exp_d, instr[11:0]);
      end
      tick();
      total++;
      if (T !== 16'h0008 || I !== exp_i) begin
         bad++;
         $display("FAIL %s_t3: T=%h I=%b want T=0008 I=%b", name, T, I, exp_i);
      end
      for (int k = 4; k <= clr_step; k++) begin
         tick();
         total++;
         if (T !== (16'h0001 << k) || D !== exp_d || I !== exp_i || SC !== k[3:0]) begin
            bad++;
            $display("FAIL %s_t%0d: T=%h SC=%0d D=%h I=%b want T=%h D=%h I=%b",
                     name, k, T, SC, D, I, 16'h0001 << k, exp_d, exp_i);
         end
      end
      tick();
      total++;
      if ({S, SC, T} !== {1'b1, 4'd0, 16'h0001}) begin
         bad++;
         $display("FAIL %s_clear: S=%b SC=%0d T=%h want S=1 SC=0 T=0001", name, S, SC, T);
      end
   endtask

   task automatic test_opcodes();
      run_instr("cla",  16'h7800, 8'h80, 1'b0, 3);
      run_instr("add",  16'h1123, 8'h02, 1'b0, 5);
      run_instr("addi", 16'h9123, 8'h02, 1'b1, 5);
      run_instr("isz",  16'h6050, 8'h40, 1'b0, 6);
      run_instr("sta",  16'h3010, 8'h08, 1'b0, 4);
      run_instr("io",   16'hF400, 8'h80, 1'b1, 3);
      run_instr("bsa",  16'h5020, 8'h20, 1'b0, 5);
   endtask

   task automatic test_hlt();
      BUS_IN = 16'h7001;
      tick();
      tick();
      tick();
      total++;
      if (T !== 16'h0008 || D !== 8'h80 || B !== 12'h001 || I !== 1'b0) begin
         bad++;
         $display("FAIL hlt_t3: T=%h D=%h B=%h I=%b want T=0008 D=80 B=001 I=0", T, D, B, I);
      end
      START = 1'b1;
      tick();
      START = 1'b0;
      total++;
      if ({S, SC, T} !== {1'b0, 4'd0, 16'h0000}) begin
         bad++;
         $display("FAIL hlt_stop: S=%b SC=%0d T=%h want S=0 SC=0 T=0000", S, SC, T);
      end
      tick();
      total++;
      if ({S, SC, T} !== {1'b0, 4'd0, 16'h0000}) begin
         bad++;
         $display("FAIL hlt_hold: S=%b SC=%0d T=%h want S=0 SC=0 T=0000", S, SC, T);
      end
      START = 1'b1;
      tick();
      START = 1'b0;
      total++;
      if ({S, SC, T} !== {1'b1, 4'd0, 16'h0001}) begin
         bad++;
         $display("FAIL hlt_restart: S=%b SC=%0d T=%h want S=1 SC=0 T=0001", S, SC, T);
      end
   endtask

   task automatic test_async_reset();
      BUS_IN = 16'h1123;
      tick();
      tick();
      tick();
      tick();
      total++;
      if (T !== 16'h0010 || SC !== 4'd4) begin
         bad++;
         $display("FAIL areset_pre: T=%h SC=%0d want T=0010 SC=4", T, SC);
      end
      #2;
      CLR_GLOBAL = 1'b1;
      #1;
      total++;
      if ({S, SC, T, D, B, I} !== {1'b0, 4'd0, 16'h0000, 8'h01, 12'h000, 1'b0}) begin
         bad++;
         $display("FAIL areset_now: S=%b SC=%0d T=%h D=%h B=%h I=%b want all cleared D=01",
                  S, SC, T, D, B, I);
      end
      #1;
      CLR_GLOBAL = 1'b0;
      tick();
      tick();
      total++;
      if ({S, SC, T} !== {1'b0, 4'd0, 16'h0000}) begin
         bad++;
         $display("FAIL areset_after: S=%b SC=%0d T=%h want S=0 SC=0 T=0000", S, SC, T);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_opcodes();
      test_hlt();
      run_instr("after_hlt", 16'h2040, 8'h04, 1'b0, 5);
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
